// File: rtl/commit_trace_buffer.sv
`default_nettype none
// commit_trace_buffer: circular record buffer for the MEM-stage retire stream with
// fill-stop, wrap and PC-trigger capture, drained oldest-first over valid/ready.
module commit_trace_buffer #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_commit_valid,
  input  logic [DATA_W-1:0] i_commit_pc,
  input  logic [DATA_W-1:0] i_commit_instr,
  input  logic              i_commit_wen,
  input  logic [REG_AW-1:0] i_commit_waddr,
  input  logic [DATA_W-1:0] i_commit_wdata,
  input  logic [1:0]        i_mode,
  input  logic              i_arm,
  input  logic              i_stop,
  input  logic [DATA_W-1:0] i_trig_pc,
  input  logic [ADDR_W:0]   i_post_count,
  output logic [1:0]        o_state,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow,
  output logic              o_triggered,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic [DATA_W-1:0] o_rd_pc,
  output logic [DATA_W-1:0] o_rd_instr,
  output logic [DATA_W-1:0] o_rd_wdata,
  output logic              o_rd_wen,
  output logic [REG_AW-1:0] o_rd_waddr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    POST    = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  localparam int REC_W = 3 * DATA_W + 1 + REG_AW;
  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   LAST_COUNT = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   ONE_COUNT  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] POST_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] POST_ZERO  = ADDR_W'(0);
  localparam logic [1:0]        MODE_OFF   = 2'd0;
  localparam logic [1:0]        MODE_FILL  = 2'd1;
  localparam logic [1:0]        MODE_TRIG  = 2'd3;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr, rd_addr;
  logic [ADDR_W:0]     count;
  logic                overflow, triggered, rd_valid, valid_next;
  logic [1:0]          mode_q;
  logic [DATA_W-1:0]   trig_q;
  logic [ADDR_W-1:0]   post_q, post_cnt, post_sat;
  logic                wr_en, set_trig, load_out, xfer;
  logic [REC_W-1:0]    mem [DEPTH];
  logic [REC_W-1:0]    wr_rec, rd_rec;
  logic [DATA_W-1:0]   rd_pc, rd_instr, rd_wdata;
  logic                rd_wen;
  logic [REG_AW-1:0]   rd_waddr;

  assign post_sat = i_post_count[ADDR_W] ? {ADDR_W{1'b1}} : i_post_count[ADDR_W-1:0];
  assign wr_rec   = {i_commit_pc, i_commit_instr, i_commit_wen, i_commit_waddr, i_commit_wdata};
  assign rd_rec   = mem[rd_addr];

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    set_trig   = 1'b0;
    load_out   = 1'b0;
    xfer       = 1'b0;
    valid_next = rd_valid;
    rd_addr    = rd_ptr;
    if (i_arm) begin
      state_next = (i_mode == MODE_OFF) ? IDLE : CAPTURE;
      valid_next = 1'b0;
    end else begin
      case (state)
        CAPTURE: begin
          if (i_commit_valid) begin
            wr_en = 1'b1;
            if (mode_q == MODE_FILL && count == LAST_COUNT) state_next = DRAIN;
            if (mode_q == MODE_TRIG && i_commit_pc == trig_q) begin
              set_trig   = 1'b1;
              state_next = (post_q == POST_ZERO) ? DRAIN : POST;
            end
          end
          if (i_stop && mode_q != MODE_FILL) state_next = DRAIN;
        end
        POST: begin
          if (i_commit_valid) begin
            wr_en = 1'b1;
            if (post_cnt == POST_ONE) state_next = DRAIN;
          end
          if (i_stop) state_next = DRAIN;
        end
        DRAIN: begin
          if (!rd_valid) begin
            if (count != '0) begin
              load_out   = 1'b1;
              valid_next = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end else if (i_rd_ready) begin
            xfer = 1'b1;
            // Prefetch the following slot so a held-high ready streams without bubbles.
            if (count == ONE_COUNT) begin
              valid_next = 1'b0;
              state_next = IDLE;
            end else begin
              load_out = 1'b1;
              rd_addr  = rd_ptr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_rec;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      triggered <= 1'b0;
      rd_valid  <= 1'b0;
      mode_q    <= '0;
      trig_q    <= '0;
      post_q    <= '0;
      post_cnt  <= '0;
      rd_pc     <= '0;
      rd_instr  <= '0;
      rd_wen    <= 1'b0;
      rd_waddr  <= '0;
      rd_wdata  <= '0;
    end else if (i_arm) begin
      mode_q    <= i_mode;
      trig_q    <= i_trig_pc;
      post_q    <= post_sat;
      post_cnt  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      triggered <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        // Full buffer: the new record displaces the oldest one.
        if (count == FULL_COUNT) begin
          rd_ptr   <= rd_ptr + 1'b1;
          overflow <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end
      if (set_trig) begin
        triggered <= 1'b1;
        post_cnt  <= post_q;
      end else if (state == POST && wr_en) begin
        post_cnt <= post_cnt - 1'b1;
      end
      if (xfer) begin
        rd_ptr <= rd_ptr + 1'b1;
        count  <= count - 1'b1;
      end
      if (load_out) begin
        rd_pc    <= rd_rec[REC_W-1 -: DATA_W];
        rd_instr <= rd_rec[REC_W-DATA_W-1 -: DATA_W];
        rd_wen   <= rd_rec[DATA_W+REG_AW];
        rd_waddr <= rd_rec[DATA_W +: REG_AW];
        rd_wdata <= rd_rec[DATA_W-1:0];
      end
      rd_valid <= valid_next;
    end
  end

  assign o_state     = state;
  assign o_count     = count;
  assign o_overflow  = overflow;
  assign o_triggered = triggered;
  assign o_rd_valid  = rd_valid;
  assign o_rd_pc     = rd_pc;
  assign o_rd_instr  = rd_instr;
  assign o_rd_wen    = rd_wen;
  assign o_rd_waddr  = rd_waddr;
  assign o_rd_wdata  = rd_wdata;

endmodule
`default_nettype wire

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Synthesisable on-chip commit tracer for the core's MEM-stage retire stream.
- Each retired instruction is captured as one record: pc, instr, GPR writeback enable, address and data.
- Records go into a parametrised circular buffer with selectable capture modes: fill-stop, wrap, and PC-trigger with post-trigger count.
- Captured records are drained oldest-first over a valid/ready port, so per-cycle dumps of pc, instr and regfile no longer need the simulator.

Parameters:
- DATA_W, 32: width of pc, instr and wdata fields.
- REG_AW, 5: GPR address width.
- DEPTH, 256: record slots; must be a power of two, at least 4.
- ADDR_W, $clog2(DEPTH): buffer pointer width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- i_commit_valid  in  1  one instruction retires this cycle.
- i_commit_pc  in  DATA_W  retiring pc.
- i_commit_instr  in  DATA_W  retiring instruction word.
- i_commit_wen  in  1  GPR write occurs.
- i_commit_waddr  in  REG_AW  GPR index.
- i_commit_wdata  in  DATA_W  GPR write data.
- i_mode  in  2  0=off, 1=fill-stop, 2=wrap, 3=trigger; sampled only on arm.
- i_arm  in  1  single-cycle pulse: clear buffer, start capture.
- i_stop  in  1  single-cycle pulse: end capture (modes 2 and 3 only).
- i_trig_pc  in  DATA_W  trigger pc; sampled on arm.
- i_post_count  in  ADDR_W+1  records kept after the trigger record; sampled on arm, saturated to DEPTH-1.
- o_state  out  2  0=IDLE, 1=CAPTURE, 2=POST, 3=DRAIN.
- o_count  out  ADDR_W+1  valid records held, 0..DEPTH.
- o_overflow  out  1  oldest records were overwritten.
- o_triggered  out  1  trigger pc was seen.
- o_rd_valid  out  1  output record valid.
- i_rd_ready  in  1  consumer accepts record.
- o_rd_pc, o_rd_instr, o_rd_wdata  out  DATA_W  output record fields.
- o_rd_wen  out  1  output record field.
- o_rd_waddr  out  REG_AW  output record field.

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE. wr_ptr, rd_ptr and o_count are 0. o_overflow, o_triggered and o_rd_valid are 0. All o_rd_* data outputs are 0. Latched mode, trigger pc and post count are 0. Buffer contents are don't-care.
- i_arm has priority over everything, in any state including mid-drain:
  - latch i_mode, i_trig_pc, i_post_count;
  - clear pointers, o_count, o_overflow, o_triggered, o_rd_valid;
  - next state CAPTURE, or IDLE if i_mode==0.
  - A commit in the arm cycle is not recorded.
- CAPTURE: each i_commit_valid writes one record at wr_ptr, then wr_ptr++ (mod DEPTH) and o_count++, saturating at DEPTH.
  - Mode 1: the write that makes o_count==DEPTH moves to DRAIN next cycle. Later commits are dropped.
  - Mode 2: once full, each write overwrites the oldest record: rd_ptr++ and o_overflow=1, o_count stays DEPTH.
  - Mode 3: as mode 2 until a commit with pc==latched trig_pc. That record is written, o_triggered=1, and the post counter is loaded with the latched post count.
    - Post count 0 goes straight to DRAIN.
    - Otherwise go to POST.
  - i_stop in CAPTURE (modes 2 and 3) goes to DRAIN next cycle. A commit in the same cycle is still recorded.
  - i_stop in mode 1 is ignored.
- POST: each commit is recorded as in wrap mode and decrements the post counter. The commit that brings it to 0 moves to DRAIN. i_stop also moves to DRAIN.
- DRAIN: commits are ignored.
  - Records leave oldest-first from rd_ptr. Read latency is 1 cycle: o_rd_valid rises the cycle after DRAIN entry if o_count>0.
  - Transfer happens when o_rd_valid && i_rd_ready. On transfer: rd_ptr++ and o_count--. The next record is presented the next cycle with no bubble (back-to-back at 1 record/cycle when ready is held high).
  - While o_rd_valid && !i_rd_ready, all o_rd_* outputs hold stable.
  - When o_count reaches 0 (or was 0 on entry): o_rd_valid=0 and the state returns to IDLE. o_overflow and o_triggered hold until the next arm.
- IDLE: commits, i_stop and i_rd_ready are ignored.
- Pointer wrap: wr_ptr and rd_ptr wrap DEPTH-1 → 0 with no gap. The full/empty decision uses o_count, never pointer equality.
- Reset asserted mid-capture or mid-drain aborts to the reset state the same edge.

Test Plan:
- Mode 1, DEPTH=8, arm, 10 commits pc=0x00400000+4k → DRAIN after the 8th; o_count=8; drain yields pc 0x00400000..0x0040001C in order; o_overflow=0; then IDLE.
- Mode 2, DEPTH=8, 13 commits then i_stop → o_overflow=1; drain yields k=5..12 (pc 0x00400014..0x00400030); rd_ptr wraps cleanly.
- Mode 3, trig_pc=0x00400020, post_count=2, 20 commits → o_triggered=1; drain yields k=3..10 with last record pc 0x00400028.
- Drain with i_rd_ready toggling 1,0,0,1 → o_rd_* stable during stall; no record lost or duplicated; wen/waddr/wdata (e.g. 1/5'd8/0xDEADBEEF) match the captured values.
- Arm pulse mid-drain, and separately reset=0 mid-capture → counters and flags cleared the same/next edge; no stale o_rd_valid; commit in the arm cycle not recorded.
